// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and strobe encodings for the data-memory arbiter
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [1:0] STROBE_NONE = 2'b00;
    localparam logic [1:0] STROBE_BYTE = 2'b01;
    localparam logic [1:0] STROBE_WORD = 2'b11;

    // Request captured in the accept cycle; err is resolved before the latch.
    typedef struct packed {
        logic        owner;
        logic        we;
        logic        word;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_req_check.sv
// rtl/dmem_req_check.sv - combinational alignment and range check for one memory request
module dmem_req_check #(
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic [31:0] addr_i,
    input  logic        word_i,
    output logic        err_o
);

    // Last touched byte in 33 bits so addresses near 2^32 cannot wrap back into range.
    logic [32:0] last_byte;

    assign last_byte = {1'b0, addr_i} + (word_i ? 33'd3 : 33'd0);
    assign err_o     = (word_i && (addr_i[1:0] != 2'b00)) || (last_byte >= 33'(MEM_DEPTH));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter/sequencer, round-robin when DMEM_ARB_RR_EN is defined
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int unsigned MEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic        req0_word,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic        req1_word,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp0_valid,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic        rsp1_err,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_word_in,
    input  logic [31:0] mem_word_out
);

    // Assertion is immediate; release is delayed two clocks to avoid metastable exits from reset.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        sel1;
    logic        grant;
    logic        win_word;
    logic [31:0] win_addr;
    logic        win_err;

`ifdef DMEM_ARB_RR_EN
    logic prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (grant && req0_valid && req1_valid) prio_d = ~prio_q;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) prio_q <= 1'b0;
        else            prio_q <= prio_d;
    end

    assign sel1 = req1_valid && (!req0_valid || prio_q);
`else
    assign sel1 = req1_valid && !req0_valid;
`endif

    assign grant      = rst_int_n && (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = grant && !sel1;
    assign req1_ready = grant && sel1;
    assign win_word   = sel1 ? req1_word : req0_word;
    assign win_addr   = sel1 ? req1_addr : req0_addr;

    dmem_req_check #(.MEM_DEPTH(MEM_DEPTH)) u_check (
        .addr_i (win_addr),
        .word_i (win_word),
        .err_o  (win_err)
    );

    always_comb begin
        req_d   = req_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_d.owner = sel1;
                    req_d.we    = sel1 ? req1_we : req0_we;
                    req_d.word  = win_word;
                    req_d.err   = win_err;
                    req_d.addr  = win_addr;
                    req_d.wdata = sel1 ? req1_wdata : req0_wdata;
                    state_d     = win_err ? RESP : ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        mem_read    = STROBE_NONE;
        mem_write   = STROBE_NONE;
        mem_address = 32'd0;
        mem_word_in = 32'd0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        rsp0_err    = 1'b0;
        rsp1_err    = 1'b0;
        rsp_rdata   = 32'd0;
        if (state_q == ACCESS) begin
            if (req_q.we) mem_write = req_q.word ? STROBE_WORD : STROBE_BYTE;
            else          mem_read  = req_q.word ? STROBE_WORD : STROBE_BYTE;
            mem_address = req_q.addr;
            mem_word_in = req_q.wdata;
        end
        if (state_q == RESP) begin
            rsp0_valid = !req_q.owner;
            rsp1_valid = req_q.owner;
            rsp0_err   = !req_q.owner && req_q.err;
            rsp1_err   = req_q.owner && req_q.err;
            if (!req_q.we && !req_q.err)
                rsp_rdata = req_q.word ? mem_word_out : {24'd0, mem_word_out[7:0]};
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, req0_word;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_ready, req1_we, req1_word;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  mem_read, mem_write;
    logic [31:0] mem_address, mem_word_in, mem_word_out;

    int n_checks = 0;
    int n_fail   = 0;
    int accepts  = 0;
    int rsps     = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_DEPTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_word(req0_word), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_word(req1_word), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_err(rsp1_err),
        .rsp_rdata(rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_word_in(mem_word_in), .mem_word_out(mem_word_out)
    );

    // Memory model: registered read; byte reads return junk upper bits.
    logic [7:0] mem [64];
    logic [5:0] ma;
    assign ma = mem_address[5:0];

    always @(posedge clk) begin
        if (mem_write == 2'b11) begin
            mem[ma]        <= mem_word_in[7:0];
            mem[ma + 6'd1] <= mem_word_in[15:8];
            mem[ma + 6'd2] <= mem_word_in[23:16];
            mem[ma + 6'd3] <= mem_word_in[31:24];
        end else if (mem_write == 2'b01) begin
            mem[ma] <= mem_word_in[7:0];
        end
        if (mem_read == 2'b11)
            mem_word_out <= {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
        else if (mem_read == 2'b01)
            mem_word_out <= {24'hABCDEF, mem[ma]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        n_checks++;
        assert (!((mem_read != 2'b00) && (mem_write != 2'b00))) else begin
            n_fail++;
            $error("FAIL strobe_excl: observed rd=%b wr=%b expected one idle", mem_read, mem_write);
        end
        if (rsp0_valid || rsp1_valid) begin
            rsps++;
            n_checks++;
            assert ((rsps <= accepts) && !(rsp0_valid && rsp1_valid)) else begin
                n_fail++;
                $error("FAIL rsp_count: observed %0d rsps expected <= %0d", rsps, accepts);
            end
        end
    end

    task automatic do_req(input bit port, input bit we, input bit word, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rdata);
        logic [1:0] s;
        s = word ? 2'b11 : 2'b01;
        @(negedge clk);
        if (!port) begin
            req0_valid = 1; req0_we = we; req0_word = word; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1; req1_we = we; req1_word = word; req1_addr = addr; req1_wdata = wdata;
        end
        #1;
        chk("ready", {30'd0, req1_ready, req0_ready}, port ? 32'd2 : 32'd1);
        if (req0_ready || req1_ready) accepts++;
        chk("idle_strobe", {28'd0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        req0_addr = 32'h0000_0021; req1_addr = 32'h0000_0022;
        req0_wdata = 32'h0BAD_0BAD; req1_wdata = 32'h0BAD_0BAD;
        #1;
        if (!exp_err) begin
            chk("strobe", {28'd0, mem_read, mem_write}, we ? {28'd0, 2'b00, s} : {28'd0, s, 2'b00});
            chk("address", mem_address, addr);
            if (we) chk("word_in", mem_word_in, wdata);
            chk("rsp_early", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            @(negedge clk);
            #1;
        end
        chk("rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
        chk("rsp_err", {31'd0, port ? rsp1_err : rsp0_err}, {31'd0, exp_err});
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_strobe", {28'd0, mem_read, mem_write}, 32'd0);
        chk("rsp_address", mem_address, 32'd0);
    endtask

    initial begin
        int g0, g1, rsp_before;
        bit exp_order [4];
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem_word_out = 32'd0;
        rst_n = 0;
        req0_valid = 1; req0_we = 0; req0_word = 1; req0_addr = 0; req0_wdata = 0;
        req1_valid = 1; req1_we = 0; req1_word = 1; req1_addr = 0; req1_wdata = 0;
        #1;
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_strobe", {28'd0, mem_read, mem_write}, 32'd0);
        chk("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1; req0_valid = 0; req1_valid = 0;
        #1;
        chk("sync_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        repeat (2) @(negedge clk);

        do_req(0, 1, 1, 32'd8,  32'hDEADBEEF, 0, 32'd0);
        do_req(0, 0, 1, 32'd8,  32'h0,        0, 32'hDEADBEEF);
        do_req(1, 1, 0, 32'd5,  32'h000000A5, 0, 32'd0);
        do_req(1, 0, 0, 32'd5,  32'h0,        0, 32'h000000A5);
        do_req(0, 0, 1, 32'd6,  32'h0,        1, 32'd0);
        do_req(0, 0, 1, 32'd62, 32'h0,        1, 32'd0);
        do_req(1, 0, 0, 32'd64, 32'h0,        1, 32'd0);
        do_req(1, 0, 1, 32'hFFFF_FFFC, 32'h0, 1, 32'd0);
        do_req(1, 1, 1, 32'd60, 32'h01020304, 0, 32'd0);
        do_req(0, 0, 1, 32'd60, 32'h0,        0, 32'h01020304);
        do_req(0, 0, 0, 32'd63, 32'h0,        0, 32'h00000001);

`ifdef DMEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 1, 1};
`endif
        g0 = 0; g1 = 0;
        req0_we = 0; req0_word = 1; req0_addr = 32'd8;
        req1_we = 0; req1_word = 0; req1_addr = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req0_valid = (g0 < 2); req1_valid = (g1 < 2);
            #1;
            chk("arb_grant", {30'd0, req1_ready, req0_ready}, exp_order[i] ? 32'd2 : 32'd1);
            if (req0_ready || req1_ready) accepts++;
            if (req1_ready) g1++; else g0++;
            @(negedge clk);
            @(negedge clk);
            #1;
            chk("arb_rsp", {30'd0, rsp1_valid, rsp0_valid}, exp_order[i] ? 32'd2 : 32'd1);
            chk("arb_rdata", rsp_rdata, exp_order[i] ? 32'h000000A5 : 32'hDEADBEEF);
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;

        req0_valid = 1; req0_we = 1; req0_word = 1; req0_addr = 32'd16; req0_wdata = 32'h11223344;
        #1;
        chk("rst_acc_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        if (req0_ready) accepts++;
        @(negedge clk);
        #1;
        chk("rst_acc_strobe", {28'd0, mem_read, mem_write}, 32'h3);
        rsp_before = rsps;
        rst_n = 0;
        #1;
        chk("rst_mid_strobe", {28'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mid_addr", mem_address, 32'd0);
        chk("rst_mid_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1; req0_valid = 0;
        repeat (2) @(negedge clk);
        chk("rst_no_rsp", rsps, rsp_before);
        do_req(0, 0, 1, 32'd16, 32'h0, 0, 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
